// File: rtl/ws2812b_bit_encoder.sv
// WS2812B serialiser: one 24-bit GRB word in per handshake, NRZ pulse-width bits out MSB-first.
// Optional latch low period after the word; ready stays low until the word (and latch) completes.
module ws2812b_bit_encoder #(
    parameter int T0H_CYCLES   = 26,
    parameter int T1H_CYCLES   = 51,
    parameter int BIT_CYCLES   = 80,
    parameter int RESET_CYCLES = 19200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_in,
    input  logic        valid,
    input  logic        latch,
    output logic        ready,
    output logic        led
);

    localparam int MAX_CYC = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
          T1H_CYCLES < BIT_CYCLES && RESET_CYCLES >= 1)) begin : g_param_err
        $error("ws2812b_bit_encoder: invalid timing parameters");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            led_q, led_d;
    logic            ready_q, ready_d;
    logic [23:0]     shift_q, shift_d;
    logic            latch_q, latch_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [4:0]      bit_q, bit_d;

    logic [CW-1:0]   th;
    logic [CW-1:0]   cyc_inc;

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        ready_d = ready_q;
        shift_d = shift_q;
        latch_d = latch_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        th      = shift_q[23] ? T1H : T0H;
        cyc_inc = cyc_q + 1'b1;

        case (state_q)
            IDLE: begin
                led_d   = 1'b0;
                ready_d = 1'b1;
                if (valid && ready_q) begin
                    shift_d = data_in;
                    latch_d = latch;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = SEND;
                    ready_d = 1'b0;
                    // Both high times are non-zero, so every bit opens high.
                    led_d   = 1'b1;
                end
            end
            SEND: begin
                ready_d = 1'b0;
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    shift_d = {shift_q[22:0], 1'b0};
                    if (bit_q == 5'd23) begin
                        bit_d = '0;
                        led_d = 1'b0;
                        if (latch_q) begin
                            state_d = LATCH;
                        end else begin
                            state_d = IDLE;
                            ready_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                        led_d = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_inc;
                    led_d = (cyc_inc < th);
                end
            end
            LATCH: begin
                led_d   = 1'b0;
                ready_d = 1'b0;
                if (cyc_q == RST_LAST) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    cyc_d = cyc_inc;
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = 1'b0;
                ready_d = 1'b1;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            led_q   <= 1'b0;
            ready_q <= 1'b1;
            shift_q <= '0;
            latch_q <= 1'b0;
            cyc_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            ready_q <= ready_d;
            shift_q <= shift_d;
            latch_q <= latch_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
        end
    end

    assign ready = ready_q;
    assign led   = led_q;

endmodule

// File: tb/tb_ws2812b_bit_encoder.sv
// Bench for ws2812b_bit_encoder: per-bit high/low widths scored against a queue filled at accept time.
module tb_ws2812b_bit_encoder;

    localparam int T0H = 26;
    localparam int T1H = 51;
    localparam int BIT = 80;
    localparam int RST = 19200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data_in;
    logic        valid;
    logic        latch;
    logic        ready;
    logic        led;

    ws2812b_bit_encoder #(
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .BIT_CYCLES  (BIT),
        .RESET_CYCLES(RST)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_in(data_in),
        .valid  (valid),
        .latch  (latch),
        .ready  (ready),
        .led    (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;   // 0: low run not checked (end of word)
    } exp_t;

    typedef struct {
        logic [23:0] data;
        logic        latch;
        int          exp_ready;   // cycle after accept edge where ready returns
        bit          busy_inj;
        bit          hold2;
        bit          pre_rst;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[5];

    int n_pass  = 0;
    int n_total = 0;
    int unexp   = 0;
    int hi_cnt  = 0;
    int lo_cnt  = 0;
    int pend_lo = 0;
    bit mon_en  = 1'b0;
    logic prev_led = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic push_word(input logic [23:0] d, input int last_lo);
        exp_t e;
        for (int i = 23; i >= 0; i--) begin
            e.hi = d[i] ? T1H : T0H;
            e.lo = (i == 0) ? last_lo : BIT - e.hi;
            sb.push_back(e);
        end
    endtask

    // One clock cycle; observe outputs at the falling edge and score pulse widths.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (led && !prev_led) begin
                if (sb.size() == 0) unexp++;
                else if (pend_lo > 0) check("lo_width", lo_cnt, pend_lo);
                pend_lo = 0;
                hi_cnt  = 1;
            end else if (led) begin
                hi_cnt++;
            end else if (prev_led) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("hi_width", hi_cnt, e.hi);
                    pend_lo = e.lo;
                end
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
        end
        prev_led = led;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 200) begin
            tick();
            k++;
        end
        check("idle_ready", int'(ready), 1);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic reset_abort();
        int n = 0;
        wait_ready();
        data_in = 24'hFFFFFF;
        latch   = 1'b0;
        valid   = 1'b1;
        push_word(24'hFFFFFF, 0);
        while (n < 500) begin
            tick();
            n++;
            valid = 1'b0;
        end
        mon_en  = 1'b0;
        sb.delete();
        pend_lo = 0;
        rst_n   = 1'b0;
        tick();
        check("abort_led", int'(led), 0);
        check("abort_ready", int'(ready), 1);
        tick();
        check("abort_led_hold", int'(led), 0);
        rst_n = 1'b1;
        idle(3);
        mon_en = 1'b1;
    endtask

    task automatic run_word(input vec_t v);
        int n      = 0;
        int lat_hi = 0;
        wait_ready();
        unexp   = 0;
        data_in = v.data;
        latch   = v.latch;
        valid   = 1'b1;
        push_word(v.data, 0);
        while (n < 30000) begin
            tick();
            n++;
            if (n == 1) begin
                check("first_hi", int'(led), 1);
                check("busy_after_accept", int'(ready), 0);
                if (!v.hold2) valid = 1'b0;
            end
            if (n == 2) valid = 1'b0;
            if (v.busy_inj && n == 100) begin
                valid   = 1'b1;
                data_in = 24'h555555;
            end
            if (v.busy_inj && n == 200) valid = 1'b0;
            if (v.latch && n > 24 * BIT && led) lat_hi++;
            if (ready) break;
        end
        check("ready_cycle", n, v.exp_ready);
        idle(100);
        check("sb_empty", sb.size(), 0);
        check("extra_pulses", unexp, 0);
        if (v.latch) check("latch_low", lat_hi, 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{24'hFF0000, 1'b0, 1921,  1'b0, 1'b0, 1'b0};
        tbl[1] = '{24'h000001, 1'b1, 21121, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{24'hAAAAAA, 1'b0, 1921,  1'b1, 1'b0, 1'b0};
        tbl[3] = '{24'h5A0F3C, 1'b0, 1921,  1'b0, 1'b1, 1'b0};
        tbl[4] = '{24'h800000, 1'b0, 1921,  1'b0, 1'b0, 1'b1};

        rst_n   = 1'b0;
        valid   = 1'b0;
        latch   = 1'b0;
        data_in = 24'h0;
        tick();
        tick();
        check("rst_ready", int'(ready), 1);
        check("rst_led", int'(led), 0);
        rst_n = 1'b1;
        idle(3);
        check("post_rst_led", int'(led), 0);
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].pre_rst) reset_abort();
            run_word(tbl[i]);
        end

        // Back-to-back: valid held high across two words.
        wait_ready();
        unexp   = 0;
        data_in = 24'h00FF00;
        latch   = 1'b0;
        valid   = 1'b1;
        push_word(24'h00FF00, BIT - T0H + 1);
        n = 0;
        tick();
        n++;
        data_in = 24'h0000FF;
        while (!ready && n < 5000) begin
            tick();
            n++;
        end
        check("b2b_first_ready", n, 1921);
        check("b2b_gap_led", int'(led), 0);
        push_word(24'h0000FF, 0);
        tick();
        n++;
        check("b2b_second_hi", int'(led), 1);
        check("b2b_second_busy", int'(ready), 0);
        valid = 1'b0;
        while (!ready && n < 10000) begin
            tick();
            n++;
        end
        check("b2b_total", n - 1, 3841);
        idle(100);
        check("b2b_sb_empty", sb.size(), 0);
        check("b2b_extra", unexp, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ws2812b_bit_encoder.md
Name: ws2812b_bit_encoder

Overview:
- Serialiser stage directly downstream of the TinyQV WS2812B peripheral register block.
- Accepts one 24-bit GRB pixel word through a valid/ready handshake.
- Emits the word MSB-first on a single pin using WS2812B NRZ pulse-width timing.
- Optionally appends the strip latch/reset low period after the word so the strip displays the shifted frame.

Parameters:
- T0H_CYCLES, 26, high time of a '0' bit in clk cycles (0.4 us at 64 MHz).
- T1H_CYCLES, 51, high time of a '1' bit in clk cycles (0.8 us at 64 MHz).
- BIT_CYCLES, 80, total bit period in clk cycles (1.25 us at 64 MHz).
- RESET_CYCLES, 19200, low time of the latch period in clk cycles (300 us at 64 MHz).
- Constraint: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES, and RESET_CYCLES >= 1. Violations are a static error.

Ports:
- clk  input  1  system clock, 64 MHz nominal.
- rst_n  input  1  reset, synchronous, active-low.
- data_in  input  24  pixel word {G,R,B}; bit 23 is sent first.
- valid  input  1  data_in/latch qualifier from the register block.
- latch  input  1  append a RESET_CYCLES low period after this word.
- ready  output  1  high when idle and able to accept a word.
- led  output  1  serial data to the strip.

Behaviour:
- All outputs are registered. While rst_n is low at a clk edge: state=IDLE, led=0, ready=1, counters cleared, capture registers cleared.
- States:
  - IDLE: led=0, ready=1.
  - SEND: ready=0.
  - LATCH: led=0, ready=0.
- Accept: valid&&ready sampled at edge E0 captures data_in into a 24-bit shift register, captures latch, and moves to SEND. ready is 0 from the cycle after E0.
- valid while ready=0 is ignored. data_in and latch changes after E0 are ignored until the next accept.
- Valid held high across E0 and the following cycle does not cause a double accept, because ready is already 0.
- SEND timing:
  - Bit k occupies BIT_CYCLES consecutive cycles. led=1 for the first TH cycles and 0 for the rest.
  - TH = T1H_CYCLES if the current bit is 1, otherwise T0H_CYCLES.
  - The first bit's high phase starts in the cycle immediately after E0.
  - Bits are contiguous with no gap. The full word takes 24*BIT_CYCLES cycles (1920 at defaults).
- Counters:
  - cyc_cnt counts 0..BIT_CYCLES-1 within a bit and is reused for LATCH. Its width is the ceiling of log2 of the larger of BIT_CYCLES and RESET_CYCLES.
  - bit_idx counts 0..23 (5 bits).
  - On the last cycle of a bit: cyc_cnt wraps to 0, the shift register shifts left by 1, and bit_idx increments.
- End of word:
  - After the last cycle of bit 0, with latch_q=0: go to IDLE. ready=1 in cycle E0+24*BIT_CYCLES+1.
  - With latch_q=1: go to LATCH and hold led=0 for exactly RESET_CYCLES cycles, then go to IDLE. ready=1 in cycle E0+24*BIT_CYCLES+RESET_CYCLES+1.
- Back-to-back words: the minimum inter-word gap is 1 cycle of led=0 (the IDLE accept cycle). This is well below the strip reset threshold, so the strip treats it as contiguous.
- Reset mid-operation: the SEND or LATCH sequence aborts at the next edge with rst_n=0. led goes to 0 immediately and the partial word is discarded. No partial pulse is produced after reset.
- No buffering beyond the single captured word. The upstream block holds the next word until ready.

Test Plan:
- Reset, then data_in=0xFF0000, latch=0, valid pulse at E0:
  - led shows 8 pulses of 51 high / 29 low, then 16 pulses of 26 high / 54 low.
  - ready=0 for cycles 1..1920 after E0 and 1 at cycle 1921.
- data_in=0x000001, latch=1:
  - bits 23..1 are 26-cycle pulses and bit 0 is a 51-cycle pulse.
  - led stays 0 for cycles 1921..21120.
  - ready=1 at cycle 21121.
- Busy ignore: accept 0xAAAAAA, then at cycle 100 drive valid=1 with data_in=0x555555:
  - the waveform stays the exact 0xAAAAAA pattern (alternating 51/26 high).
  - no second word is sent until valid is re-asserted while ready=1.
- Reset mid-frame: drive rst_n=0 at cycle 500 of a word:
  - led=0 and ready=1 from the next edge.
  - after release, a new accept of 0x800000 produces a fresh first pulse of 51 cycles.
- Back-to-back: upstream holds valid=1 with two words 0x00FF00 then 0x0000FF, each with latch=0:
  - the second word's first high begins 2 cycles after the first word's last low cycle.
  - total time is 3841 cycles.
- Handshake hold: valid held high for 2 cycles across the accept edge -> exactly one word is transmitted.
